// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the add-chain sequencer.
// Holds the state encoding, default widths and operand slicing.
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_OPS_DEF = 7;
    localparam int W_IN_DEF  = 13;
    localparam int W_OUT_DEF = 13;

    localparam int MAX_OPS  = 16;
    localparam int MAX_W    = 32;
    localparam int MAX_FLAT = MAX_OPS * MAX_W;

    // Operand i of a flattened vector whose slots are w bits wide.
    function automatic logic [MAX_W-1:0] op_slice(
        input logic [MAX_FLAT-1:0] flat,
        input int                  w,
        input int                  i
    );
        logic [MAX_FLAT-1:0] s;
        logic [MAX_W:0]      m;
        s = flat >> (i * w);
        m = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        return s[MAX_W-1:0] & m[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/shared_adder.sv
// Single combinational adder shared by every accumulation step.
// Carry-out is the extra MSB of a one-bit-wider sum.
module shared_adder #(
    parameter int W = 13
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/add_chain_sched.sv
// Sums N_OPS latched operands through one shared adder, one add per cycle.
// Start on r_enable in IDLE; w_enable pulses for one cycle when done.
import add_sched_pkg::*;

module add_chain_sched #(
    parameter int N_OPS = N_OPS_DEF,
    parameter int W_IN  = W_IN_DEF,
    parameter int W_OUT = W_OUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_enable,
    input  logic [N_OPS*W_IN-1:0] ops,
    output logic                  w_enable,
    output logic [W_OUT-1:0]      result,
    output logic                  ovf,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_OPS);
    localparam int N_SLOT = 2 ** IDX_W;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [W_OUT-1:0]        acc_q, acc_d;
    logic                    cry_q, cry_d;
    logic [W_OUT-1:0]        result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic [N_OPS*W_IN-1:0]   ops_q, ops_d;

    logic [W_OUT-1:0]        op_arr [N_SLOT];
    logic [W_OUT-1:0]        add_sum;
    logic                    add_co;
    logic                    last;

    // Slots past N_OPS exist only so idx never addresses a hole.
    for (genvar g = 0; g < N_SLOT; g++) begin : g_op
        if (g < N_OPS) begin : g_v
            assign op_arr[g] =
                W_OUT'(op_slice(MAX_FLAT'(ops_q), W_IN, g));
        end else begin : g_z
            assign op_arr[g] = '0;
        end
    end

    shared_adder #(
        .W(W_OUT)
    ) u_add (
        .a_i  (acc_q),
        .b_i  (op_arr[idx_q]),
        .sum_o(add_sum),
        .co_o (add_co)
    );

    assign last = (idx_q == IDX_W'(N_OPS - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cry_d    = cry_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ops_d    = ops_q;
        unique case (state_q)
            IDLE: begin
                if (r_enable) begin
                    ops_d   = ops;
                    acc_d   = '0;
                    cry_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = add_sum;
                cry_d = cry_q | add_co;
                idx_d = idx_q + IDX_W'(1);
                // Visible outputs only move on the final add.
                if (last) begin
                    result_d = add_sum;
                    ovf_d    = cry_q | add_co;
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            cry_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cry_q    <= cry_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ops_q    <= ops_d;
        end
    end

    assign w_enable = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign result   = result_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_add_chain_sched.sv
// Directed and random checks of add_chain_sched against a sum model.
// Expected sums come from plain integer arithmetic over the operands.
module tb_add_chain_sched;

    localparam int N  = 7;
    localparam int WI = 13;
    localparam int WO = 13;
    localparam int MODV = 1 << WO;

    typedef int unsigned opv_t [N];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r_enable;
    logic [N*WI-1:0] ops;
    logic          w_enable;
    logic [WO-1:0] result;
    logic          ovf;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    add_chain_sched #(
        .N_OPS(N),
        .W_IN (WI),
        .W_OUT(WO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r_enable(r_enable),
        .ops     (ops),
        .w_enable(w_enable),
        .result  (result),
        .ovf     (ovf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*WI-1:0] pack(input opv_t v);
        logic [N*WI-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*WI +: WI] = WI'(v[i]);
        return p;
    endfunction

    function automatic int unsigned total(input opv_t v);
        int unsigned t;
        t = 0;
        for (int i = 0; i < N; i++) t += v[i];
        return t;
    endfunction

    function automatic opv_t rand_ops();
        opv_t v;
        for (int i = 0; i < N; i++) v[i] = $urandom_range(0, MODV - 1);
        return v;
    endfunction

    function automatic opv_t fill(input int unsigned x);
        opv_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    task automatic do_run(input opv_t v, input string tag, input bit zap);
        int lat;
        int unsigned t;
        t = total(v);
        ops = pack(v);
        r_enable = 1'b1;
        @(posedge clk); #1;
        r_enable = 1'b0;
        if (zap) ops = '0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (w_enable) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, lat, N);
        check({tag, "_res"}, 32'(result), t % MODV);
        check({tag, "_ovf"}, 32'(ovf), 32'(t >= MODV));
        @(posedge clk); #1;
        check({tag, "_wen_lo"}, 32'(w_enable), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        opv_t v;
        opv_t hist [40];
        int unsigned starts [$];
        int pulses;
        int unsigned t;

        rst_n = 1'b0;
        r_enable = 1'b0;
        ops = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wen", 32'(w_enable), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        v = '{123, 234, 345, 456, 567, 678, 789};
        do_run(v, "seq", 1'b0);
        check("seq_3192", 32'(result), 32'd3192);
        repeat (10) @(posedge clk);
        #1;
        check("hold_res", 32'(result), 32'd3192);
        check("hold_ovf", 32'(ovf), 32'd0);

        do_run(fill(MODV - 1), "max", 1'b0);
        check("max_8185", 32'(result), 32'd8185);
        do_run(fill(1), "ones", 1'b0);
        check("ones_7", 32'(result), 32'd7);

        v = rand_ops();
        t = total(v);
        ops = pack(v);
        r_enable = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        for (int c = 1; c <= 25; c++) begin
            r_enable = (c == 3 || c == N + 1);
            @(posedge clk); #1;
            if (w_enable) pulses++;
        end
        r_enable = 1'b0;
        check("ign_pulses", pulses, 1);
        check("ign_res", 32'(result), t % MODV);
        check("ign_busy", 32'(busy), 32'd0);

        do_run(rand_ops(), "snap", 1'b1);
        do_run(fill(MODV - 1), "pre_rst", 1'b0);

        ops = pack(rand_ops());
        r_enable = 1'b1;
        @(posedge clk); #1;
        r_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res", 32'(result), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wen", 32'(w_enable), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (w_enable) pulses++;
        end
        check("mid_rst_nopulse", pulses, 0);
        check("mid_rst_idle", 32'(busy), 32'd0);

        for (int s = 0; s < 30; s += N + 2) starts.push_back(s);
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            hist[e] = rand_ops();
            ops = pack(hist[e]);
            r_enable = (e < 30);
            @(posedge clk); #1;
            if (w_enable) begin
                if (pulses < starts.size()) begin
                    check("rep_edge", e, starts[pulses] + N);
                    check("rep_res", 32'(result),
                          total(hist[starts[pulses]]) % MODV);
                    check("rep_ovf", 32'(ovf),
                          32'(total(hist[starts[pulses]]) >= MODV));
                end
                pulses++;
            end
        end
        r_enable = 1'b0;
        check("rep_count", pulses, starts.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
